battleship_cursor_ctrl: RTL and testbench

BATTLESHIP_CURSOR_CTRL -- requirements
Module: battleship_cursor_ctrl

---
 rtl/battleship_cursor_ctrl.sv | 159 +++++++++++++++
 tb/tb_battleship_cursor_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// battleship_cursor_ctrl
//
// Moves a targeting cursor over a GRID_N x GRID_N board from debounced button
// levels, with press-edge stepping, wrap-around, hold-to-repeat, and a
// fire-request handshake that captures the target square.
//
// Parameters
//   GRID_N   : board rows/cols (2..8)
//   HOLD_DLY : cycles a direction is held before the first auto-repeat step
//   RPT_PER  : cycles between subsequent auto-repeat steps (1..HOLD_DLY)
//
// Ports
//   clk                  in   system clock
//   rst_n                in   asynchronous active-low reset
//   en                   in   targeting phase; buttons ignored when 0
//   btn_up/down/left/right/fire  in  debounced, clk-synchronous levels
//   fire_ack             in   game FSM consumed the shot
//   cur_row, cur_col     out  registered cursor position
//   fire_req             out  shot request, held until fire_ack
//   fire_row, fire_col   out  target captured at fire time
// -----------------------------------------------------------------------------
module battleship_cursor_ctrl #(
    parameter int GRID_N   = 8,
    parameter int HOLD_DLY = 50_000_000,
    parameter int RPT_PER  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       fire_ack,
    output logic [2:0] cur_row,
    output logic [2:0] cur_col,
    output logic       fire_req,
    output logic [2:0] fire_row,
    output logic [2:0] fire_col
);

    localparam int               CNT_W      = $clog2(HOLD_DLY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(HOLD_DLY);
    localparam logic [CNT_W-1:0] CNT_TRIG   = CNT_W'(HOLD_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_DLY - RPT_PER);
    localparam logic [2:0]       LAST       = 3'(GRID_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_REL
    } fire_state_t;

    fire_state_t      state;
    logic [4:0]       prev;       // {fire, up, down, left, right}
    logic [CNT_W-1:0] hold_cnt;

    logic [4:0]       lvl;
    logic [4:0]       edge_v;
    logic [3:0]       dir;
    logic [3:0]       dir_prev;
    logic             hold_rpt;
    logic [CNT_W-1:0] hold_next;
    logic             step_up, step_down, step_left, step_right;
    logic [2:0]       row_next, col_next;

    assign lvl      = {btn_fire, btn_up, btn_down, btn_left, btn_right};
    assign edge_v   = en ? (lvl & ~prev) : 5'b0;
    assign dir      = lvl[3:0];
    assign dir_prev = prev[3:0];

    // Hold counter: runs only while the same nonzero direction set is held.
    // Hitting the trigger value emits one repeat step and reloads so the
    // next trigger lands RPT_PER cycles later.
    always_comb begin
        // NOTE: every signal of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        hold_next = '0;
        hold_rpt  = 1'b0;
        if (en && dir != 4'b0 && dir == dir_prev) begin
            if (hold_cnt == CNT_TRIG) begin
                hold_rpt  = 1'b1;
                hold_next = CNT_RELOAD;
            end else if (hold_cnt != CNT_MAX) begin
                hold_next = hold_cnt + CNT_W'(1);
            end else begin
                hold_next = CNT_MAX;
            end
        end
    end

    assign step_up    = edge_v[3] | (hold_rpt & btn_up);
    assign step_down  = edge_v[2] | (hold_rpt & btn_down);
    assign step_left  = edge_v[1] | (hold_rpt & btn_left);
    assign step_right = edge_v[0] | (hold_rpt & btn_right);

    // Opposing steps on one axis cancel; the two axes are independent.
    always_comb begin
        row_next = cur_row;
        col_next = cur_col;
        if (step_down && !step_up)
            row_next = (cur_row == LAST) ? 3'd0 : cur_row + 3'd1;
        else if (step_up && !step_down)
            row_next = (cur_row == 3'd0) ? LAST : cur_row - 3'd1;
        if (step_right && !step_left)
            col_next = (cur_col == LAST) ? 3'd0 : cur_col + 3'd1;
        else if (step_left && !step_right)
            col_next = (cur_col == 3'd0) ? LAST : cur_col - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fire_req <= 1'b0;
            fire_row <= 3'd0;
            fire_col <= 3'd0;
            cur_row  <= 3'd0;
            cur_col  <= 3'd0;
            hold_cnt <= '0;
            // Buttons held through reset must be released before they count.
            prev     <= 5'b11111;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            prev <= lvl;
            case (state)
                IDLE, WAIT_REL: begin
                    hold_cnt <= hold_next;
                    if (state == IDLE && edge_v[4]) begin
                        // Fire wins over any move sampled in the same cycle.
                        state    <= REQ;
                        fire_req <= 1'b1;
                        fire_row <= cur_row;
                        fire_col <= cur_col;
                    end else begin
                        cur_row <= row_next;
                        cur_col <= col_next;
                        if (state == WAIT_REL && !btn_fire)
                            state <= IDLE;
                    end
                end
                REQ: begin
                    // Cursor and hold counter frozen; only the ack matters.
                    if (fire_ack) begin
                        fire_req <= 1'b0;
                        state    <= btn_fire ? WAIT_REL : IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    fire_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battleship_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_battleship_cursor_ctrl
//
// Self-checking bench for battleship_cursor_ctrl (GRID_N=8, HOLD_DLY=8,
// RPT_PER=4). A behavioural model tracks the cursor with modular arithmetic,
// tracks how long the current direction set has been held, and tracks the
// shot handshake as "pending" / "awaiting release" flags.
// -----------------------------------------------------------------------------
module tb_battleship_cursor_ctrl;

    localparam int GRID_N   = 8;
    localparam int HOLD_DLY = 8;
    localparam int RPT_PER  = 4;

    // Button vector layout used throughout: {fire, up, down, left, right}
    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_FIRE  = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_fire = 1'b0;
    logic       fire_ack = 1'b0;
    logic [2:0] cur_row, cur_col, fire_row, fire_col;
    logic       fire_req;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    int         m_row, m_col, m_frow, m_fcol;
    bit         m_pend, m_wait;
    logic [4:0] m_prev;
    int         m_held;

    battleship_cursor_ctrl #(
        .GRID_N  (GRID_N),
        .HOLD_DLY(HOLD_DLY),
        .RPT_PER (RPT_PER)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_fire (btn_fire),
        .fire_ack (fire_ack),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .fire_req (fire_req),
        .fire_row (fire_row),
        .fire_col (fire_col)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] dut_pack();
        return {cur_row, cur_col, fire_req, fire_row, fire_col};
    endfunction

    function automatic logic [12:0] model_pack();
        return {3'(m_row), 3'(m_col), m_pend, 3'(m_frow), 3'(m_fcol)};
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0; m_frow = 0; m_fcol = 0;
        m_pend = 0; m_wait = 0; m_prev = 5'b11111; m_held = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step(input logic [4:0] b, input logic e, input logic ack);
        logic [4:0] edges;
        bit rpt;
        int dr, dc;
        edges = e ? (b & ~m_prev) : 5'b0;
        if (m_pend) begin
            if (ack) begin
                m_pend = 0;
                m_wait = b[4];
            end
        end else begin
            if (!e || b[3:0] == 4'b0 || b[3:0] != m_prev[3:0]) m_held = 0;
            else m_held++;
            rpt = (m_held >= HOLD_DLY) && ((m_held - HOLD_DLY) % RPT_PER == 0);
            if (!m_wait && edges[4]) begin
                m_pend = 1;
                m_frow = m_row;
                m_fcol = m_col;
            end else begin
                dr = int'(edges[2] | (rpt & b[2])) - int'(edges[3] | (rpt & b[3]));
                dc = int'(edges[0] | (rpt & b[0])) - int'(edges[1] | (rpt & b[1]));
                m_row = (m_row + dr + GRID_N) % GRID_N;
                m_col = (m_col + dc + GRID_N) % GRID_N;
                if (m_wait && !b[4]) m_wait = 0;
            end
        end
        m_prev = b;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic tick(input logic [4:0] b, input logic e = 1'b1, input logic ack = 1'b0);
        {btn_fire, btn_up, btn_down, btn_left, btn_right} = b;
        en = e;
        fire_ack = ack;
        @(posedge clk);
        model_step(b, e, ack);
        #1;
    endtask

    // Reset with the given buttons held; released away from a clock edge.
    task automatic do_reset(input logic [4:0] b);
        {btn_fire, btn_up, btn_down, btn_left, btn_right} = b;
        en = 1'b1;
        fire_ack = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(B_NONE);
        vectors++;
        if (dut_pack() !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h required 0", dut_pack());
        end
    endtask

    task automatic test_single_step();
        do_reset(B_NONE);
        tick(B_NONE);
        tick(B_LEFT);
        vectors++;
        if (cur_col !== 3'd7 || cur_row !== 3'd0 || dut_pack() !== model_pack()) begin
            miscompares++;
            $display("FAIL left_wrap: got (%0d,%0d) required (0,7)", cur_row, cur_col);
        end
        tick(B_NONE);
    endtask

    task automatic test_hold_repeat();
        do_reset(B_NONE);
        tick(B_NONE);
        for (int i = 0; i < 20; i++) begin
            tick(B_DOWN);
            vectors++;
            if (dut_pack() !== model_pack()) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got %h required %h", i, dut_pack(), model_pack());
            end
        end
        vectors++;
        if (cur_row !== 3'd4 || cur_col !== 3'd0) begin
            miscompares++;
            $display("FAIL hold_final: got (%0d,%0d) required (4,0)", cur_row, cur_col);
        end
        tick(B_NONE);
    endtask

    task automatic test_cancel_diag();
        do_reset(B_NONE);
        tick(B_NONE);
        tick(B_UP | B_DOWN);
        vectors++;
        if (cur_row !== 3'd0 || cur_col !== 3'd0) begin
            miscompares++;
            $display("FAIL up_down_cancel: got (%0d,%0d) required (0,0)", cur_row, cur_col);
        end
        tick(B_NONE);
        tick(B_UP | B_RIGHT);
        vectors++;
        if (cur_row !== 3'd7 || cur_col !== 3'd1 || dut_pack() !== model_pack()) begin
            miscompares++;
            $display("FAIL diagonal: got (%0d,%0d) required (7,1)", cur_row, cur_col);
        end
        tick(B_NONE);
    endtask

    task automatic test_fire_and_freeze();
        logic [6:0] seq[$];   // {en, ack, buttons}
        do_reset(B_NONE);
        tick(B_NONE);
        for (int i = 0; i < 3; i++) begin tick(B_DOWN);  tick(B_NONE); end
        for (int i = 0; i < 5; i++) begin tick(B_RIGHT); tick(B_NONE); end
        vectors++;
        if (cur_row !== 3'd3 || cur_col !== 3'd5) begin
            miscompares++;
            $display("FAIL reach_3_5: got (%0d,%0d) required (3,5)", cur_row, cur_col);
        end
        tick(B_FIRE | B_LEFT);
        vectors++;
        if (fire_req !== 1'b1 || fire_row !== 3'd3 || fire_col !== 3'd5 ||
            cur_row !== 3'd3 || cur_col !== 3'd5) begin
            miscompares++;
            $display("FAIL fire_beats_move: got req=%b fire=(%0d,%0d) cur=(%0d,%0d) required req=1 fire=(3,5) cur=(3,5)",
                     fire_req, fire_row, fire_col, cur_row, cur_col);
        end
        // Frozen in REQ, then ack while fire held.
        tick(B_FIRE | B_RIGHT);
        tick(B_FIRE);
        tick(B_FIRE, 1'b1, 1'b1);
        vectors++;
        if (fire_req !== 1'b0 || cur_row !== 3'd3 || cur_col !== 3'd5) begin
            miscompares++;
            $display("FAIL ack_frozen: got req=%b cur=(%0d,%0d) required req=0 cur=(3,5)",
                     fire_req, cur_row, cur_col);
        end
        // Awaiting release: movement allowed, no new request; then re-arm.
        seq = '{{2'b10, B_FIRE}, {2'b10, B_FIRE | B_LEFT}, {2'b10, B_FIRE},
                {2'b11, B_FIRE}, {2'b10, B_NONE}, {2'b10, B_FIRE},
                {2'b10, B_FIRE}, {2'b11, B_NONE}, {2'b10, B_NONE}};
        foreach (seq[i]) begin
            tick(seq[i][4:0], seq[i][6], seq[i][5]);
            vectors++;
            if (dut_pack() !== model_pack()) begin
                miscompares++;
                $display("FAIL wait_release_step%0d: got %h required %h", i, dut_pack(), model_pack());
            end
        end
        vectors++;
        if (cur_col !== 3'd4 || fire_col !== 3'd4 || fire_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rearm_fire: got cur_col=%0d fire_col=%0d req=%b required 4 4 0",
                     cur_col, fire_col, fire_req);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset(B_NONE);
        tick(B_NONE);
        tick(B_FIRE);
        vectors++;
        if (fire_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_before_reset: got %b required 1", fire_req);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (fire_req !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_drop: got %b required 0", fire_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(B_NONE);
        vectors++;
        if (dut_pack() !== 13'd0) begin
            miscompares++;
            $display("FAIL after_reset_idle: got %h required 0", dut_pack());
        end
    endtask

    task automatic test_hold_through_reset();
        do_reset(B_UP);
        for (int i = 0; i < 5; i++) tick(B_UP);
        vectors++;
        if (cur_row !== 3'd0 || dut_pack() !== model_pack()) begin
            miscompares++;
            $display("FAIL held_through_reset: got row=%0d required 0", cur_row);
        end
        tick(B_NONE);
        tick(B_UP);
        vectors++;
        if (cur_row !== 3'd7) begin
            miscompares++;
            $display("FAIL repress_after_reset: got row=%0d required 7", cur_row);
        end
        tick(B_NONE);
    endtask

    task automatic test_enable();
        logic [6:0] seq[$];
        do_reset(B_NONE);
        seq = '{{2'b10, B_NONE}, {2'b00, B_RIGHT}, {2'b00, B_RIGHT}, {2'b10, B_RIGHT},
                {2'b10, B_NONE}, {2'b00, B_FIRE}, {2'b10, B_FIRE}, {2'b10, B_NONE},
                {2'b10, B_FIRE}, {2'b00, B_FIRE | B_DOWN}, {2'b00, B_NONE},
                {2'b01, B_NONE}, {2'b10, B_DOWN}};
        foreach (seq[i]) begin
            tick(seq[i][4:0], seq[i][6], seq[i][5]);
            vectors++;
            if (dut_pack() !== model_pack()) begin
                miscompares++;
                $display("FAIL enable_step%0d: got %h required %h", i, dut_pack(), model_pack());
            end
        end
        vectors++;
        if (cur_col !== 3'd0 || cur_row !== 3'd1 || fire_req !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_final: got (%0d,%0d) req=%b required (1,0) req=0",
                     cur_row, cur_col, fire_req);
        end
        tick(B_NONE);
    endtask

    task automatic test_random();
        logic [4:0] b;
        logic e, ack;
        do_reset(B_NONE);
        b = B_NONE;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) b = 5'($urandom_range(31));
            e   = ($urandom_range(9) != 0);
            ack = ($urandom_range(3) == 0);
            tick(b, e, ack);
            vectors++;
            if (dut_pack() !== model_pack()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h required %h", i, dut_pack(), model_pack());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_step();
        test_hold_repeat();
        test_cancel_diag();
        test_fire_and_freeze();
        test_reset_mid_req();
        test_hold_through_reset();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
